md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Optional trace of HI/LO commits enabled by defining MD_DISPLAY_EN.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] WPC,
    output logic        busy,
    output logic [31:0] md_rd
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [1:0]  op_q,    op_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic [63:0] prod_w;
    logic [31:0] quot_w, rem_w;
    logic        commit_hi_w, commit_lo_w;

    // Signed divide works on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    logic        a_neg_w, b_neg_w;
    logic [31:0] mag_a_w, mag_b_w, uq_w, ur_w;

    always_comb begin
        if (op_q[0]) begin
            prod_w = {32'b0, a_q} * {32'b0, b_q};
        end else begin
            prod_w = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        end
        a_neg_w = ~op_q[0] & a_q[31];
        b_neg_w = ~op_q[0] & b_q[31];
        mag_a_w = a_neg_w ? (32'd0 - a_q) : a_q;
        mag_b_w = b_neg_w ? (32'd0 - b_q) : b_q;
        uq_w    = (mag_b_w == 32'd0) ? 32'd0 : (mag_a_w / mag_b_w);
        ur_w    = (mag_b_w == 32'd0) ? 32'd0 : (mag_a_w % mag_b_w);
        quot_w  = (a_neg_w ^ b_neg_w) ? (32'd0 - uq_w) : uq_w;
        rem_w   = a_neg_w ? (32'd0 - ur_w) : ur_w;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        commit_hi_w = 1'b0;
        commit_lo_w = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = rs_data;
                    b_d     = rt_data;
                    op_d    = md_op;
                    cnt_d   = md_op[1] ? DIV_N : MULT_N;
                    state_d = S_RUN;
                end else if (hilo_we) begin
                    if (hilo_sel) begin
                        hi_d        = rs_data;
                        commit_hi_w = 1'b1;
                    end else begin
                        lo_d        = rs_data;
                        commit_lo_w = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (!op_q[1]) begin
                        hi_d        = prod_w[63:32];
                        lo_d        = prod_w[31:0];
                        commit_hi_w = 1'b1;
                        commit_lo_w = 1'b1;
                    end else if (b_q != 32'd0) begin
                        hi_d        = rem_w;
                        lo_d        = quot_w;
                        commit_hi_w = 1'b1;
                        commit_lo_w = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign md_rd = hilo_sel ? hi_q : lo_q;

`ifdef MD_DISPLAY_EN
    logic [31:0] wpc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wpc_q <= 32'd0;
        end else if (state_q == S_IDLE && start) begin
            wpc_q <= WPC;
        end
    end

    // Arithmetic commits report the PC of the launching instruction, direct writes the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (commit_hi_w)
                $display("%0t@%h: $hi <= %h", $time, (state_q == S_RUN) ? wpc_q : WPC, hi_d);
            if (commit_lo_w)
                $display("%0t@%h: $lo <= %h", $time, (state_q == S_RUN) ? wpc_q : WPC, lo_d);
        end
    end
`else
    logic unused_wpc;
    logic unused_commit;
    assign unused_wpc    = ^WPC;
    assign unused_commit = commit_hi_w ^ commit_lo_w;
`endif

endmodule
